// File: rtl/clock_divider_bank.sv
// -----------------------------------------------------------------------------
// clock_divider_bank
//
// Multi-channel, run-time programmable clock divider. Each channel counts
// system clock edges up to its active terminal count N and then wraps. On
// each wrap the channel emits a one-cycle tick and toggles its divided clock.
// The tick period is N+1 cycles. The divided clock has a 50% duty cycle and a
// period of 2*(N+1) cycles.
//
// A new divisor is written into a per-channel shadow register and marked
// pending. It is promoted to the active divisor only on that channel's next
// wrap, or on a global sync strobe. This keeps every half-period whole.
//
// Parameters
//   CHANNELS     number of independent channels (1..16)
//   CNT_WIDTH    counter / divisor width in bits
//   DEFAULT_DIV  divisor every channel holds after reset
//
// Ports
//   clock      in   system clock, all state on posedge
//   reset_n    in   asynchronous active-low reset
//   enable     in   per-channel run enable
//   sync       in   one-cycle strobe: restart and phase-align all channels
//   load       in   one-cycle strobe: write load_div into channel load_sel
//   load_sel   in   target channel of a load (out-of-range values ignored)
//   load_div   in   new terminal count N
//   scaledclk  out  per-channel divided clock (registered)
//   tick       out  per-channel wrap strobe (registered)
//   pending    out  per-channel "shadow divisor not yet applied" flag
// -----------------------------------------------------------------------------
module clock_divider_bank #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = 99,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [CHANNELS-1:0]  enable,
  input  logic                 sync,
  input  logic                 load,
  input  logic [SEL_W-1:0]     load_sel,
  input  logic [CNT_WIDTH-1:0] load_div,
  output logic [CHANNELS-1:0]  scaledclk,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  pending
);

  localparam logic [CNT_WIDTH-1:0] DIV_RESET = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  // Per-channel state
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] div_a_q, div_a_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] div_s_q, div_s_d;
  logic [CHANNELS-1:0]                pend_q,  pend_d;
  logic [CHANNELS-1:0]                sclk_q,  sclk_d;
  logic [CHANNELS-1:0]                tick_q,  tick_d;

  // Per-channel decode helpers
  logic [CHANNELS-1:0]                load_hit_s;
  logic [CHANNELS-1:0]                wrap_s;

  // Decode which channel a load targets and which channels wrap this cycle.
  // A load_sel at or beyond CHANNELS matches no channel, so it is dropped.
  always_comb begin
    load_hit_s = {CHANNELS{1'b0}};
    wrap_s     = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (load && (int'(load_sel) == i)) begin
        load_hit_s[i] = 1'b1;
      end else begin
        load_hit_s[i] = 1'b0;
      end
      // The counter never passes div_a, so equality is the wrap condition.
      if (enable[i] && (cnt_q[i] == div_a_q[i])) begin
        wrap_s[i] = 1'b1;
      end else begin
        wrap_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic for every channel: sync, then wrap/count/hold, then load.
  always_comb begin
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_s_d = div_s_q;
    pend_d  = pend_q;
    sclk_d  = sclk_q;
    tick_d  = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync) begin
        // Phase-align every channel and flush any pending divisor right away.
        // A load on the same edge bypasses the shadow and takes effect now.
        cnt_d[i]  = CNT_ZERO;
        sclk_d[i] = 1'b0;
        tick_d[i] = 1'b0;
        pend_d[i] = 1'b0;
        if (load_hit_s[i]) begin
          div_a_d[i] = load_div;
          div_s_d[i] = load_div;
        end else if (pend_q[i]) begin
          div_a_d[i] = div_s_q[i];
        end else begin
          div_a_d[i] = div_a_q[i];
        end
      end else begin
        if (wrap_s[i]) begin
          cnt_d[i]  = CNT_ZERO;
          sclk_d[i] = ~sclk_q[i];
          tick_d[i] = 1'b1;
          // Promote the shadow only at a wrap so no half-period is cut short.
          if (pend_q[i]) begin
            div_a_d[i] = div_s_q[i];
            pend_d[i]  = 1'b0;
          end else begin
            div_a_d[i] = div_a_q[i];
          end
        end else if (enable[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else begin
          // Disabled: count, phase and divisor freeze; tick stays low.
          cnt_d[i] = cnt_q[i];
        end
        // A load landing on the wrap edge is applied after the old shadow was
        // promoted above, so the new value waits for the next wrap.
        if (load_hit_s[i]) begin
          div_s_d[i] = load_div;
          pend_d[i]  = 1'b1;
        end else begin
          div_s_d[i] = div_s_d[i];
        end
      end
    end
  end

  // State registers, cleared asynchronously to the reset divisor.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= CNT_ZERO;
        div_a_q[i] <= DIV_RESET;
        div_s_q[i] <= DIV_RESET;
      end
      pend_q <= {CHANNELS{1'b0}};
      sclk_q <= {CHANNELS{1'b0}};
      tick_q <= {CHANNELS{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_s_q <= div_s_d;
      pend_q  <= pend_d;
      sclk_q  <= sclk_d;
      tick_q  <= tick_d;
    end
  end

  // Outputs come straight from registers.
  assign scaledclk = sclk_q;
  assign tick      = tick_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_bank
//
// Directed bench for clock_divider_bank (4 channels, 16-bit, default 99).
// Stimulus pushes the hand-computed (edge, scaledclk) of every expected tick
// into a per-channel queue. A monitor pops an entry whenever the DUT raises a
// tick. Edges are counted from reset release: edge_n == k at the negedge after
// the k-th enabled posedge.
// -----------------------------------------------------------------------------
module tb_clock_divider_bank;

  localparam int CH = 4;
  localparam int CW = 16;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] enable;
  logic          sync;
  logic          load;
  logic [1:0]    load_sel;
  logic [CW-1:0] load_div;
  logic [CH-1:0] scaledclk;
  logic [CH-1:0] tick;
  logic [CH-1:0] pending;

  int edge_n   = 0;
  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int   e;
    logic sc;
  } exp_t;

  exp_t exp_q [CH][$];
  exp_t mon_e;

  clock_divider_bank #(
    .CHANNELS   (CH),
    .CNT_WIDTH  (CW),
    .DEFAULT_DIV(99)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .sync     (sync),
    .load     (load),
    .load_sel (load_sel),
    .load_div (load_div),
    .scaledclk(scaledclk),
    .tick     (tick),
    .pending  (pending)
  );

  always #5 clock = ~clock;

  // Count posedges since reset release.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  // Monitor: every tick must match the oldest expected entry of its channel.
  always @(negedge clock) begin
    if (reset_n) begin
      for (int c = 0; c < CH; c++) begin
        if (tick[c]) begin
          n_checks++;
          if (exp_q[c].size() == 0) begin
            n_err++;
            $display("FAIL tick_unexpected ch%0d: tick at edge %0d, required none", c, edge_n);
          end else begin
            mon_e = exp_q[c].pop_front();
            if (mon_e.e != edge_n || mon_e.sc !== scaledclk[c]) begin
              n_err++;
              $display("FAIL tick ch%0d: got edge %0d sc %0b, required edge %0d sc %0b",
                       c, edge_n, scaledclk[c], mon_e.e, mon_e.sc);
            end
          end
        end
      end
    end
  end

  task automatic push(input int c, input int e, input logic sc);
    exp_t x;
    x.e  = e;
    x.sc = sc;
    exp_q[c].push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Advance to the negedge where edge_n == k.
  task automatic wait_edge(input int k);
    while (edge_n < k) @(negedge clock);
    chk("schedule", edge_n, k);
  endtask

  task automatic issue_load(input int k, input logic [1:0] sel, input logic [CW-1:0] div);
    wait_edge(k - 1);
    load     = 1'b1;
    load_sel = sel;
    load_div = div;
    @(negedge clock);
    load     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    enable   = 4'h0;
    sync     = 1'b0;
    load     = 1'b0;
    load_sel = 2'd0;
    load_div = 16'd0;
    repeat (3) @(negedge clock);
    chk("reset_sclk", 32'(scaledclk), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_pend", 32'(pending), 32'h0);

    // Defaults: period 100 ticks, 200-cycle divided clock.
    enable  = 4'hF;
    reset_n = 1'b1;
    for (int c = 0; c < CH; c++) begin
      for (int m = 1; m <= 5; m++) push(c, 100 * m, logic'(m % 2));
    end
    wait_edge(150);
    chk("sclk_high_half", 32'(scaledclk), 32'hF);
    wait_edge(250);
    chk("sclk_low_half", 32'(scaledclk), 32'h0);
    wait_edge(399);
    chk("pend_idle", 32'(pending), 32'h0);

    // Channel 1 reloaded to 4 mid-count; applies at its wrap on edge 500.
    for (int j = 1; j <= 6; j++) push(1, 500 + 5 * j, logic'((j % 2) == 0));
    issue_load(431, 2'd1, 16'd4);
    chk("pend_load_ch1", 32'(pending), 32'h2);
    wait_edge(499);
    chk("pend_hold_ch1", 32'(pending), 32'h2);
    wait_edge(500);
    chk("pend_clear_ch1", 32'(pending), 32'h0);

    // Channel 2 loaded with 0, then sync at edge 531 applies it at once.
    issue_load(521, 2'd2, 16'd0);
    chk("pend_load_ch2", 32'(pending), 32'h4);
    wait_edge(530);
    chk("pend_hold_ch2", 32'(pending), 32'h4);
    for (int e = 532; e <= 790; e++) push(2, e, logic'(((e - 531) % 2) == 1));
    for (int j = 1; 531 + 5 * j <= 790; j++) push(1, 531 + 5 * j, logic'((j % 2) == 1));
    push(3, 631, 1'b1);
    sync = 1'b1;
    @(negedge clock);
    sync = 1'b0;
    chk("sync_sclk", 32'(scaledclk), 32'h0);
    chk("sync_tick", 32'(tick), 32'h0);
    chk("sync_pend", 32'(pending), 32'h0);

    // Channel 0 paused at count 37 for 20 edges; wraps 63 edges after resume.
    wait_edge(568);
    enable[0] = 1'b0;
    push(0, 651, 1'b1);
    push(0, 751, 1'b0);
    wait_edge(569);
    chk("hold_ch0_start", {30'd0, tick[0], scaledclk[0]}, 32'h0);
    wait_edge(588);
    chk("hold_ch0_end", {30'd0, tick[0], scaledclk[0]}, 32'h0);
    enable[0] = 1'b1;

    // Channel 3: 9 pending, then 19 loaded exactly on the wrap edge 731.
    issue_load(700, 2'd3, 16'd9);
    chk("pend_load_ch3", 32'(pending), 32'h8);
    push(3, 731, 1'b0);
    push(3, 741, 1'b1);
    push(3, 761, 1'b0);
    push(3, 781, 1'b1);
    issue_load(731, 2'd3, 16'd19);
    chk("pend_wrapload_ch3", 32'(pending), 32'h8);
    wait_edge(740);
    chk("pend_hold_ch3", 32'(pending), 32'h8);
    wait_edge(741);
    chk("pend_clear_ch3", 32'(pending), 32'h0);

    // Asynchronous reset between edges, then defaults again.
    wait_edge(790);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_sclk", 32'(scaledclk), 32'h0);
    chk("areset_tick", 32'(tick), 32'h0);
    chk("areset_pend", 32'(pending), 32'h0);
    for (int c = 0; c < CH; c++) begin
      push(c, 100, 1'b1);
      push(c, 200, 1'b0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    wait_edge(205);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("missing_ticks_ch%0d", c), 32'(exp_q[c].size()), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
